// File: rtl/fpoperations.sv
// Shared FPU constants for the integer-to-float converter.
// Holds rounding-mode encodings, exponent biases, mantissa widths and the
// per-stage payload structs that travel down the conversion pipeline.
package fpoperations;

    // fpcsr rounding-mode field encodings
    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

    localparam int unsigned INT_W    = 64;
    localparam int unsigned LZ_W     = 7;
    localparam int unsigned RES_W    = 80;

    localparam int unsigned BIAS_SNG = 127;
    localparam int unsigned BIAS_DBL = 1023;
    localparam int unsigned BIAS_EXT = 16383;

    localparam int unsigned MANT_SNG = 23;
    localparam int unsigned MANT_DBL = 52;
    localparam int unsigned MANT_EXT = 63;

    typedef struct packed {
        logic sng;
        logic dbl;
        logic ext;
    } fmt_t;

    // S1 payload: sign/magnitude split of the operand plus per-op controls
    typedef struct packed {
        logic             sign;
        logic [INT_W-1:0] mag;
        rm_e              rm;
        fmt_t             fmt;
    } s1_t;

    // S2 payload: normalised magnitude (bit 63 set unless zero)
    typedef struct packed {
        logic             sign;
        logic [INT_W-1:0] norm;
        logic [LZ_W-1:0]  lz;
        logic             zero;
        rm_e              rm;
        fmt_t             fmt;
    } s2_t;

    // True when exactly one target format is selected
    function automatic logic fmt_onehot(input fmt_t f);
        return ({f.sng, f.dbl, f.ext} == 3'b100) ||
               ({f.sng, f.dbl, f.ext} == 3'b010) ||
               ({f.sng, f.dbl, f.ext} == 3'b001);
    endfunction

endpackage

// File: rtl/cvt_lzc64.sv
// Combinational 64-bit leading-zero counter.
// Ports: i_val  - value to scan
//        o_lz_c - number of leading zeros, 0..64 (64 when i_val is zero)
module cvt_lzc64
    import fpoperations::*;
(
    input  logic [INT_W-1:0] i_val,
    output logic [LZ_W-1:0]  o_lz_c
);

    // Ascending scan so the highest set bit wins
    always_comb begin
        o_lz_c = LZ_W'(INT_W);
        for (int i = 0; i < int'(INT_W); i++) begin
            if (i_val[i]) begin
                o_lz_c = LZ_W'(63 - i);
            end
        end
    end

endmodule

// File: rtl/cvt_i_fp_mod.sv
// Integer-to-floating-point converter, three-stage pipeline.
//   S1: sign/magnitude capture, S2: normalise, S3: round and pack.
// Ports:
//   clk, rst (async active-low), clkEn (advance enable, 0 freezes all stages)
//   en/tag_in/A/is32b/isSigned/isSNG/isDBL/isEXT/fpcsr - issue side
//   res (80b, right-aligned), res_en, tag_out, flags {inexact, invalid}
// Optional feature macro CVTIF_FLAGS_EN: when defined the flags are computed
// and registered with res; otherwise flags is tied to zero.
module cvt_i_fp_mod
    import fpoperations::*;
#(
    parameter int unsigned RM_LSB = 0,
    parameter int unsigned TAG_W  = 9
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             en,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [63:0]      A,
    input  logic             is32b,
    input  logic             isSigned,
    input  logic             isSNG,
    input  logic             isDBL,
    input  logic             isEXT,
    input  logic [31:0]      fpcsr,
    output logic [79:0]      res,
    output logic             res_en,
    output logic [TAG_W-1:0] tag_out,
    output logic [1:0]       flags
);

    // ---------------- S1: extend, sign, magnitude ----------------
    logic [INT_W-1:0] w_val;
    logic             w_sign;
    logic [INT_W-1:0] w_mag;

    // Two's-complement negate also yields 2^63 for INT64_MIN as unsigned
    always_comb begin
        w_val = A;
        if (is32b) begin
            w_val = isSigned ? {{32{A[31]}}, A[31:0]} : {32'b0, A[31:0]};
        end
        w_sign = isSigned & w_val[63];
        w_mag  = w_sign ? (~w_val + 64'd1) : w_val;
    end

    s1_t              r_s1;
    logic             r_s1_v;
    logic [TAG_W-1:0] r_s1_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v   <= 1'b0;
            r_s1     <= '0;
            r_s1_tag <= '0;
        end else if (clkEn) begin
            r_s1_v <= en;
            if (en) begin
                r_s1.sign <= w_sign;
                r_s1.mag  <= w_mag;
                r_s1.rm   <= rm_e'(fpcsr[RM_LSB +: 2]);
                r_s1.fmt  <= '{sng: isSNG, dbl: isDBL, ext: isEXT};
                r_s1_tag  <= tag_in;
            end
        end
    end

    // ---------------- S2: normalise ----------------
    logic [LZ_W-1:0] w_lz;

    cvt_lzc64 u_lzc (
        .i_val  (r_s1.mag),
        .o_lz_c (w_lz)
    );

    s2_t              r_s2;
    logic             r_s2_v;
    logic [TAG_W-1:0] r_s2_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_v   <= 1'b0;
            r_s2     <= '0;
            r_s2_tag <= '0;
        end else if (clkEn) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2.sign <= r_s1.sign;
                r_s2.norm <= r_s1.mag << w_lz;
                r_s2.lz   <= w_lz;
                r_s2.zero <= (r_s1.mag == 64'd0);
                r_s2.rm   <= r_s1.rm;
                r_s2.fmt  <= r_s1.fmt;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // ---------------- S3: round and pack ----------------
    logic             w_fmt_ok;
    logic [INT_W-1:0] w_kept;
    logic             w_guard;
    logic             w_sticky;
    logic             w_lsb;
    logic             w_up;
    logic [INT_W:0]   w_rounded;
    logic             w_carry;
    logic [15:0]      w_bias;
    logic [15:0]      w_exp;
    logic [RES_W-1:0] w_res;

    // kept holds the integer bit plus m fraction bits, right-aligned
    always_comb begin
        w_fmt_ok  = fmt_onehot(r_s2.fmt);
        w_kept    = r_s2.norm;
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        w_lsb     = r_s2.norm[0];
        w_bias    = 16'(BIAS_EXT);
        w_up      = 1'b0;
        w_rounded = '0;
        w_carry   = 1'b0;
        w_exp     = '0;
        w_res     = '0;

        if (r_s2.fmt.sng) begin
            w_kept   = INT_W'(r_s2.norm[63 -: (MANT_SNG + 1)]);
            w_guard  = r_s2.norm[62 - MANT_SNG];
            w_sticky = |r_s2.norm[61 - MANT_SNG:0];
            w_lsb    = r_s2.norm[63 - MANT_SNG];
            w_bias   = 16'(BIAS_SNG);
        end else if (r_s2.fmt.dbl) begin
            w_kept   = INT_W'(r_s2.norm[63 -: (MANT_DBL + 1)]);
            w_guard  = r_s2.norm[62 - MANT_DBL];
            w_sticky = |r_s2.norm[61 - MANT_DBL:0];
            w_lsb    = r_s2.norm[63 - MANT_DBL];
            w_bias   = 16'(BIAS_DBL);
        end

        case (r_s2.rm)
            RM_RNE:  w_up = w_guard & (w_sticky | w_lsb);
            RM_RZ:   w_up = 1'b0;
            RM_RUP:  w_up = ~r_s2.sign & (w_guard | w_sticky);
            RM_RDN:  w_up = r_s2.sign & (w_guard | w_sticky);
            default: w_up = 1'b0;
        endcase

        // Carry out leaves only the bit above the integer bit set, so the
        // fraction field reads back as zero without extra masking
        w_rounded = (INT_W + 1)'(w_kept) + (INT_W + 1)'(w_up);
        if (r_s2.fmt.sng) begin
            w_carry = w_rounded[MANT_SNG + 1];
        end else if (r_s2.fmt.dbl) begin
            w_carry = w_rounded[MANT_DBL + 1];
        end else begin
            w_carry = w_rounded[MANT_EXT + 1];
        end

        w_exp = w_bias + 16'd63 - 16'(r_s2.lz) + 16'(w_carry);

        if (w_fmt_ok && !r_s2.zero) begin
            if (r_s2.fmt.sng) begin
                w_res = RES_W'({r_s2.sign, w_exp[7:0], w_rounded[MANT_SNG-1:0]});
            end else if (r_s2.fmt.dbl) begin
                w_res = RES_W'({r_s2.sign, w_exp[10:0], w_rounded[MANT_DBL-1:0]});
            end else begin
                w_res = {r_s2.sign, w_exp[14:0], 1'b1, w_rounded[MANT_EXT-1:0]};
            end
        end
    end

    logic [RES_W-1:0] r_res;
    logic             r_res_en;
    logic [TAG_W-1:0] r_tag_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res     <= '0;
            r_res_en  <= 1'b0;
            r_tag_out <= '0;
        end else if (clkEn) begin
            r_res_en <= r_s2_v;
            if (r_s2_v) begin
                r_res     <= w_res;
                r_tag_out <= r_s2_tag;
            end
        end
    end

    assign res     = r_res;
    assign res_en  = r_res_en;
    assign tag_out = r_tag_out;

`ifdef CVTIF_FLAGS_EN
    logic [1:0] w_flags_c;
    logic [1:0] r_flags;

    // Zero input has no guard/sticky bits set, so it is naturally exact
    assign w_flags_c = {w_fmt_ok & (w_guard | w_sticky), ~w_fmt_ok};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= 2'b00;
        end else if (clkEn && r_s2_v) begin
            r_flags <= w_flags_c;
        end
    end

    assign flags = r_flags;
`else
    assign flags = 2'b00;
`endif

    // Bits that no format consumes
    logic w_unused;
    assign w_unused = ^{w_rounded[INT_W], w_rounded[MANT_EXT], w_exp[15], fpcsr};

endmodule

// File: doc/cvt_i_fp_mod.md
Name: cvt_I_FP_mod

Overview:
Integer-to-floating-point converter; the inverse of the FP-to-integer converter on the u5 lane of the low FPU cluster.
- Takes a 32- or 64-bit signed or unsigned integer and produces a single, double or extended result.
- Rounds per the fpcsr rounding mode.
- Three-stage pipeline, stalled by the same clkEn/alt-enable scheme as the rest of the FPU.

Parameters:
RM_LSB, 0, bit position of the 2-bit rounding-mode field in fpcsr (00 RNE, 01 RZ, 10 RUp/+inf, 11 RDown/-inf).
TAG_W, 9, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  clock; all state on posedge (negedge under swapedge, as elsewhere in the FPU).
rst  input  1  asynchronous, active-low reset.
clkEn  input  1  pipeline advance enable; 0 freezes every stage.
en  input  1  issue valid; sampled only when clkEn=1.
tag_in  input  TAG_W  tag carried with the operation.
A  input  64  integer operand.
is32b  input  1  use only A[31:0].
isSigned  input  1  two's-complement source; else unsigned.
isSNG  input  1  single-precision target.
isDBL  input  1  double-precision target.
isEXT  input  1  80-bit extended target.
fpcsr  input  32  control/status register; only the RM field is read, sampled at issue.
res  output  80  result, right-aligned: single in [31:0], double in [63:0], extended in [79:0]; unused upper bits zero.
res_en  output  1  result valid strobe.
tag_out  output  TAG_W  tag of the retiring operation.
flags  output  2  {inexact, invalid}; invalid is set when the format selects are not one-hot.

Behaviour:
- Reset (rst=0, async): every stage valid bit cleared; res=0, res_en=0, tag_out=0, flags=0. Any in-flight operation is discarded without retiring.
- Latency: exactly 3 clkEn=1 cycles from an issue to res_en; one issue per cycle accepted; no backpressure other than clkEn.
- clkEn=0: all stage registers hold; res, res_en, tag_out and flags hold their current values; en is ignored.
- S1, capture and sign:
  - For is32b, sign-extend or zero-extend A[31:0] to 64 bits according to isSigned.
  - sign = isSigned & MSB.
  - mag = |value|, 64 bits unsigned; INT64_MIN gives mag = 2^63 exactly.
  - Latch the RM field and the format selects.
- S2, normalise:
  - lz = leading-zero count of mag (0..64).
  - Shift mag left by lz so that bit 63 is 1.
  - zero = (mag==0).
- S3, round and pack:
  - Mantissa width: m = 23 / 52 / 63 for SNG / DBL / EXT.
  - Guard = shifted bit (62-m); sticky = OR of all lower bits.
  - Round-up condition by mode:
    - RNE: guard & (sticky | lsb).
    - RZ: never.
    - RUp: ~sign & (guard|sticky).
    - RDown: sign & (guard|sticky).
  - Rounding carry-out increments the exponent and re-zeroes the mantissa.
  - Exponent = bias + 63 - lz (+1 on carry); bias = 127 / 1023 / 16383.
  - EXT packs {sign, exp15, explicit integer bit 1, frac63}.
  - No overflow is possible for these widths.
- Zero input: res = +0 for every mode and format; flags = 0.
- inexact = guard|sticky. EXT is always exact.
- Format selects not one-hot: res=0, invalid=1, res_en still asserted.
- Back-to-back issues with differing formats or modes are independent; every per-op control travels with its stage.

Optional Feature:
CVTIF_FLAGS_EN
- Defined: flags are computed as above and registered with res.
- Undefined: flags tied to 2'b0 and the guard/sticky flag logic removed; rounding itself is unchanged.

Decomposition:
- Shared package (fpoperations): rounding-mode encodings; bias constants 127/1023/16383; format mantissa widths.
- One sub-module, cvt_lzc64: combinational 64-bit leading-zero counter, instantiated in S2.

Test Plan:
1. A=1, unsigned, isSNG, RNE, en for one cycle -> third clkEn cycle: res=0x3F800000, res_en=1, flags=0.
2. A=0xFFFFFFFFFFFFFFFF, signed, isDBL -> res=0xBFF0000000000000; A=0x8000000000000000, signed, isDBL -> res=0xC3E0000000000000.
3. A=0x01000001 (2^24+1), isSNG:
   - RNE -> res=0x4B800000, inexact=1.
   - RUp -> res=0x4B800001.
   - RZ -> res=0x4B800000.
4. A=0xFFFFFFFFFFFFFFFF, unsigned, isEXT -> res=0x403EFFFFFFFFFFFFFFFF, inexact=0; the same A with isDBL and RNE -> res=0x43F0000000000000 (rounding carry), inexact=1.
5. Issue on three consecutive cycles, then hold clkEn=0 for 4 cycles -> outputs frozen during the stall; results retire in issue order with their tags once clkEn returns to 1.
6. Assert rst low while two ops are in flight -> res_en=0 and res=0 immediately; no retirement after rst is released; A=0 with isDBL issued next -> res=0.
